// File: rtl/i2s_tx_pkg.sv
// ============================================================================
// i2s_tx_pkg : shared constants and state encoding for the I2S transmitter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package i2s_tx_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DIV_W_DEF      = 8;
    localparam int FRAME_W_DEF    = 2 * DATA_W_DEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int frame_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
// ============================================================================
// i2s_tx_fifo : synchronous stereo-frame FIFO with level/full/empty
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2s_tx_fifo
    import i2s_tx_pkg::*;
#(
    parameter int WIDTH = FRAME_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped regardless of a simultaneous pop.
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_count == c_full_count);
    assign empty   = (r_count == '0);
    assign level   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2s_tx_master.sv
// ============================================================================
// i2s_tx_master : I2S (Philips) master transmitter with frame FIFO, BCLK/WS gen
// Revision      : 1.0
// ============================================================================
`default_nettype none

module i2s_tx_master
    import i2s_tx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DIV_W      = DIV_W_DEF
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          en,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_W-1:0]             wr_left,
    input  logic [DATA_W-1:0]             wr_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          clr_underflow,
    output logic                          i2s_clk,
    output logic                          ws,
    output logic                          sd_out,
    output logic                          busy
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] c_ws_lo    = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] c_ws_hi    = BIT_W'(FRAME_W - 2);
    localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(FRAME_W - 1);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_lat;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_first;
    logic                r_bclk;
    logic                r_ws;
    logic                r_sd;
    logic                r_underflow;
    logic [BIT_W-1:0]    r_bit;
    logic [FRAME_W-1:0]  r_shift;

    logic                w_active;
    logic                w_div_tc;
    logic                w_fall;
    logic                w_stop;
    logic                w_load;
    logic                w_ws_next;
    logic                w_full;
    logic                w_empty;
    logic [FRAME_W-1:0]  w_head;
    logic [FRAME_W-1:0]  w_frame;

    i2s_tx_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .push    (wr_valid),
        .pop     (w_load),
        .wr_data ({wr_left, wr_right}),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    assign w_active  = (r_state != ST_IDLE);
    assign w_div_tc  = (r_div_cnt == r_div_lat);
    assign w_fall    = w_active && (r_first || (w_div_tc && r_bclk));
    // Drain ends on the boundary event of the next frame, which is never loaded.
    assign w_stop    = w_fall && (r_state == ST_DRAIN) && !en && (r_bit == '0);
    assign w_load    = w_fall && !w_stop && (r_bit == '0);
    assign w_frame   = w_empty ? '0 : w_head;
    assign w_ws_next = (r_bit >= c_ws_lo) && (r_bit <= c_ws_hi);

    assign wr_ready  = !w_full;
    assign underflow = r_underflow;
    assign i2s_clk   = r_bclk;
    assign ws        = r_ws;
    assign sd_out    = r_sd;
    // DRAIN still clocks out the current frame, so it counts as busy.
    assign busy      = w_active;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_div_lat   <= '0;
            r_div_cnt   <= '0;
            r_first     <= 1'b0;
            r_bclk      <= 1'b0;
            r_ws        <= 1'b0;
            r_sd        <= 1'b0;
            r_underflow <= 1'b0;
            r_bit       <= '0;
            r_shift     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state   <= ST_RUN;
                        r_div_lat <= clk_div;
                        r_div_cnt <= '0;
                        r_first   <= 1'b1;
                        r_bit     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!en) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en)          r_state <= ST_RUN;
                    else if (w_stop) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_active) begin
                r_first <= 1'b0;
                // The divider holds on the first cycle so bit 0 has a full low phase of setup.
                if (!r_first) begin
                    if (w_div_tc) begin
                        r_div_cnt <= '0;
                        r_bclk    <= ~r_bclk;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                if (w_stop) begin
                    r_bclk    <= 1'b0;
                    r_ws      <= 1'b0;
                    r_sd      <= 1'b0;
                    r_div_cnt <= '0;
                end else if (w_fall) begin
                    if (r_bit == '0) begin
                        r_sd    <= w_frame[FRAME_W-1];
                        r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
                    end else begin
                        r_sd    <= r_shift[FRAME_W-1];
                        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                    end
                    r_ws  <= w_ws_next;
                    r_bit <= (r_bit == c_last_bit) ? '0 : r_bit + 1'b1;
                end
            end

            if (w_load && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_master.sv
// ============================================================================
// tb_i2s_tx_master : directed self-checking bench for i2s_tx_master
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx_master;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 8;
    localparam logic [63:0] c_ws_pat = 64'h0000_0000_0001_FFFE;

    logic                 HCLK = 1'b0;
    logic                 HRESET = 1'b1;
    logic                 en = 1'b0;
    logic [DIV_W-1:0]     clk_div = '0;
    logic                 wr_valid = 1'b0;
    logic [DATA_W-1:0]    wr_left = '0;
    logic [DATA_W-1:0]    wr_right = '0;
    logic                 clr_underflow = 1'b0;
    logic                 wr_ready;
    logic [3:0]           fifo_level;
    logic                 underflow;
    logic                 i2s_clk;
    logic                 ws;
    logic                 sd_out;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    i2s_tx_master #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .en            (en),
        .clk_div       (clk_div),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_left       (wr_left),
        .wr_right      (wr_right),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .clr_underflow (clr_underflow),
        .i2s_clk       (i2s_clk),
        .ws            (ws),
        .sd_out        (sd_out),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        wr_valid = 1'b1;
        wr_left  = l;
        wr_right = r;
        @(negedge HCLK);
        wr_valid = 1'b0;
    endtask

    // Collects sd_out/ws on BCLK rising edges, sampled at HCLK negedges.
    task automatic capture(input int nbits, output logic [63:0] d, output logic [63:0] w,
                           output int cyc, output logic ok);
        int   got;
        logic prev;
        got  = 0;
        cyc  = 0;
        d    = '0;
        w    = '0;
        ok   = 1'b1;
        prev = i2s_clk;
        while (got < nbits) begin
            @(negedge HCLK);
            cyc++;
            if (i2s_clk && !prev) begin
                d = {d[62:0], sd_out};
                w = {w[62:0], ws};
                got++;
            end
            prev = i2s_clk;
            if (cyc > 3000 && got < nbits) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge HCLK);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] d, w, d2, w2;
        logic [31:0] frame;
        int          c, c2;
        logic        ok, ok2;

        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_i2s_clk", 64'(i2s_clk), 64'd0);
        chk("rst_ws", 64'(ws), 64'd0);
        chk("rst_sd_out", 64'(sd_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);

        // Single frame, clk_div=1
        push(16'hA5A5, 16'h3C3C);
        chk("single_level", 64'(fifo_level), 64'd1);
        clk_div = 8'd1;
        en = 1'b1;
        @(negedge HCLK);
        en = 1'b0;
        chk("single_busy", 64'(busy), 64'd1);
        capture(32, d, w, c, ok);
        chk("single_timeout", 64'(ok), 64'd1);
        chk("single_data", d, 64'hA5A5_3C3C);
        chk("single_ws", w, c_ws_pat);
        chk("single_cycles", 64'(c), 64'd127);
        wait_idle("single");
        chk("single_i2s_clk", 64'(i2s_clk), 64'd0);
        chk("single_level_after", 64'(fifo_level), 64'd0);
        chk("single_no_underflow", 64'(underflow), 64'd0);

        // Underflow; clear held during the setting event must lose
        en = 1'b1;
        clr_underflow = 1'b1;
        @(negedge HCLK);
        chk("uf_before_fall", 64'(underflow), 64'd0);
        @(negedge HCLK);
        en = 1'b0;
        clr_underflow = 1'b0;
        chk("uf_first_fall", 64'(underflow), 64'd1);
        capture(32, d, w, c, ok);
        chk("uf_timeout", 64'(ok), 64'd1);
        chk("uf_data", d, 64'd0);
        wait_idle("uf");
        chk("uf_sticky", 64'(underflow), 64'd1);
        clr_underflow = 1'b1;
        @(negedge HCLK);
        clr_underflow = 1'b0;
        chk("uf_cleared", 64'(underflow), 64'd0);

        // Full FIFO: 9 pushes, 9th dropped
        for (int k = 0; k < 9; k++) begin
            push(16'hC000 | 16'(k), 16'h5000 | 16'(k));
            if (k == 7) begin
                chk("full_level8", 64'(fifo_level), 64'd8);
                chk("full_wr_ready", 64'(wr_ready), 64'd0);
            end
        end
        chk("full_level_after9", 64'(fifo_level), 64'd8);
        clk_div = 8'd2;
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            capture(32, d, w, c, ok);
            chk($sformatf("full_timeout%0d", k), 64'(ok), 64'd1);
            frame = (k < 8) ? {16'hC000 | 16'(k), 16'h5000 | 16'(k)} : 32'd0;
            chk($sformatf("full_frame%0d", k), d, 64'(frame));
            if (k == 7) chk("full_no_uf_yet", 64'(underflow), 64'd0);
        end
        en = 1'b0;
        chk("full_uf_frame", 64'(underflow), 64'd1);
        wait_idle("full");
        chk("full_wr_ready_after", 64'(wr_ready), 64'd1);
        clr_underflow = 1'b1;
        @(negedge HCLK);
        clr_underflow = 1'b0;

        // Drain: en dropped at bit 5 of frame 0 with two frames queued
        push(16'h1234, 16'h5678);
        push(16'h9ABC, 16'hDEF0);
        clk_div = 8'd1;
        en = 1'b1;
        capture(6, d, w, c, ok);
        en = 1'b0;
        capture(26, d2, w2, c2, ok2);
        chk("drain_timeout", 64'(ok && ok2), 64'd1);
        frame = {d[5:0], d2[25:0]};
        chk("drain_frame0", 64'(frame), 64'h1234_5678);
        wait_idle("drain");
        chk("drain_i2s_clk", 64'(i2s_clk), 64'd0);
        chk("drain_level", 64'(fifo_level), 64'd1);
        chk("drain_no_uf", 64'(underflow), 64'd0);
        en = 1'b1;
        @(negedge HCLK);
        en = 1'b0;
        capture(32, d, w, c, ok);
        chk("drain_f1_timeout", 64'(ok), 64'd1);
        chk("drain_frame1", d, 64'h9ABC_DEF0);
        wait_idle("drain_f1");
        chk("drain_level_after", 64'(fifo_level), 64'd0);

        // Reset mid-run at bit 10
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        en = 1'b1;
        capture(11, d, w, c, ok);
        chk("mrst_timeout", 64'(ok), 64'd1);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("mrst_i2s_clk", 64'(i2s_clk), 64'd0);
        chk("mrst_ws", 64'(ws), 64'd0);
        chk("mrst_sd_out", 64'(sd_out), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_level", 64'(fifo_level), 64'd0);
        chk("mrst_wr_ready", 64'(wr_ready), 64'd1);
        HRESET = 1'b0;
        en = 1'b0;
        @(negedge HCLK);
        chk("mrst_stays_idle", 64'(busy), 64'd0);

        // Max rate, three back-to-back frames
        push(16'h8001, 16'h7FFE);
        push(16'h0F0F, 16'hF0F0);
        push(16'hCAFE, 16'hBEEF);
        clk_div = 8'd0;
        en = 1'b1;
        capture(32, d, w, c, ok);
        chk("max_f0_timeout", 64'(ok), 64'd1);
        chk("max_f0_data", d, 64'h8001_7FFE);
        chk("max_f0_ws", w, c_ws_pat);
        chk("max_f0_cycles", 64'(c), 64'd65);
        capture(32, d, w, c, ok);
        chk("max_f1_timeout", 64'(ok), 64'd1);
        chk("max_f1_data", d, 64'h0F0F_F0F0);
        chk("max_f1_ws", w, c_ws_pat);
        chk("max_f1_cycles", 64'(c), 64'd64);
        capture(16, d, w, c, ok);
        en = 1'b0;
        capture(16, d2, w2, c2, ok2);
        chk("max_f2_timeout", 64'(ok && ok2), 64'd1);
        frame = {d[15:0], d2[15:0]};
        chk("max_f2_data", 64'(frame), 64'hCAFE_BEEF);
        frame = {w[15:0], w2[15:0]};
        chk("max_f2_ws", 64'(frame), c_ws_pat);
        chk("max_f2_cycles", 64'(c + c2), 64'd64);
        wait_idle("max");
        chk("max_no_uf", 64'(underflow), 64'd0);
        chk("max_level", 64'(fifo_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
